uart_word_tx: RTL and testbench
===============================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate; BAUD_TICKS = CLK_FREQ_HZ / BAUD_RATE (integer division).
REQ-003 SHALL have parameter WORD_BYTES, default 4, range 1..8, bytes per accepted word.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; used only when parity is compiled in.
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 s_data  input  8*WORD_BYTES  word to transmit.
REQ-009 s_valid  input  1  s_data is valid.
REQ-010 s_ready  output  1  block can accept a word.
REQ-011 tx_line  output  1  serial line, idle high; registered.
REQ-012 busy  output  1  a word is being serialised.
REQ-013 word_done  output  1  single-cycle pulse when the final stop bit of a word completes.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- s_ready = (state == IDLE).
- busy = (state != IDLE).
REQ-015 SHALL accept a word on the rising edge where s_valid && s_ready, latching s_data into an internal shift register; s_data is ignored at all other times.
REQ-016 SHALL drive tx_line low starting the cycle after acceptance (IDLE->START), with zero extra latency.
REQ-017 SHALL hold every line bit (start, data, parity, stop) for exactly BAUD_TICKS cycles, timed by a tick counter that clears at each bit boundary.
REQ-018 SHALL send each byte as: start(0), 8 data bits LSB first, [parity], STOP_BITS stop bits(1).
REQ-019 SHALL send bytes least-significant byte first: byte k = s_data[8k+7:8k].
REQ-020 SHALL go STOP->START directly between bytes of the same word, with no idle gap.
REQ-021 SHALL go STOP->IDLE on the last tick of the final stop bit of byte WORD_BYTES-1, and SHALL pulse word_done on that same cycle.
REQ-022 SHALL keep s_ready high on the cycle after word_done, so back-to-back words produce one continuous frame stream with no idle bit between words.
REQ-023 SHALL frame one word in exactly WORD_BYTES*(10+(STOP_BITS-1)+P)*BAUD_TICKS cycles, where P = 1 if parity is compiled in, else 0.
REQ-024 SHALL NOT react to s_valid while busy; s_valid held high while busy has no effect.
REQ-025 SHALL reject BAUD_TICKS < 2, WORD_BYTES outside 1..8, or STOP_BITS outside {1,2} at elaboration with a fatal error.
REQ-026 SHALL size the tick, bit and byte counters with $clog2 of their maxima; counters SHALL never wrap past their terminal value.

Reset
REQ-027 On rst_n low:
- state = IDLE, tx_line = 1, busy = 0, s_ready = 1, word_done = 0
- all counters cleared to 0, shift register cleared to 0
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; tx_line SHALL return high asynchronously with no partial byte completion.
REQ-029 After reset release, the first rising edge with s_valid high SHALL be accepted.

Configuration
REQ-030 Macro UART_WORD_TX_PARITY_EN:
- When defined: SHALL insert the PARITY state after bit 7 of every byte, transmitting the XOR of the 8 data bits, inverted when PARITY_ODD = 1.
- When undefined: PARITY state and logic SHALL be absent; DATA->STOP directly; PARITY_ODD is ignored.

Verification
All scenarios use CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 (BAUD_TICKS=10), WORD_BYTES=4, STOP_BITS=1, unless stated.
REQ-031 Single word:
- Stimulus: s_data=32'hA5C3_0F81 pulsed for 1 cycle, no parity.
- Response: line bytes 81,0F,C3,A5 in order, each bit 10 cycles; word_done exactly 400 cycles after acceptance; busy high throughout.
REQ-032 Back-to-back:
- Stimulus: s_valid held high with 32'h0000_00FF then 32'hFFFF_FF00.
- Response: second word accepted the cycle after word_done; no high gap longer than one stop bit between words; 800 cycles total.
REQ-033 Parity (macro defined, PARITY_ODD=0):
- Stimulus: WORD_BYTES=1, data 8'h07.
- Response: parity bit = 1; frame is 110 cycles.
- Repeat with PARITY_ODD=1: parity bit = 0.
REQ-034 Two stop bits:
- Stimulus: STOP_BITS=2, WORD_BYTES=2, data 16'h1234.
- Response: each byte ends with 20 high cycles; word_done at cycle 220.
REQ-035 Reset mid-frame:
- Stimulus: assert rst_n low during bit 3 of byte 1.
- Response: tx_line=1, busy=0, s_ready=1 immediately; the next word transmits correctly from its start bit.
REQ-036 Ignored valid:
- Stimulus: pulse s_valid with 32'hDEAD_BEEF while busy.
- Response: that word is never transmitted; the in-flight word is unaffected.

Source files
------------

// File: rtl/uart_word_tx_if.sv
// Word handshake between a producer and uart_word_tx.
// A word transfers on a rising edge where s_valid and s_ready are both high.
interface uart_word_tx_if #(
    parameter int WORD_BYTES = 4
) ();
    logic [8*WORD_BYTES-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_word_tx.sv
// UART transmitter that serialises a multi-byte word, least-significant byte first.
// Optional parity bit per byte is compiled in with `define UART_WORD_TX_PARITY_EN.
module uart_word_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int WORD_BYTES  = 4,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_word_tx_if.slave        s_if,
    output logic                 tx_line,
    output logic                 busy,
    output logic                 word_done,
    output logic [2:0]           dbg_state
);

    localparam int BAUD_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int TICK_W     = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
    localparam int BYTE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int DATA_W     = 8 * WORD_BYTES;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_TICKS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORD_BYTES - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    if (BAUD_TICKS < 2) begin : g_bad_baud
        $fatal(1, "uart_word_tx: BAUD_TICKS must be at least 2");
    end
    if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_bytes
        $fatal(1, "uart_word_tx: WORD_BYTES must be in 1..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_word_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          bit_cnt;     // data bit index, reused as stop-bit index
    logic [BYTE_W-1:0]   byte_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                tick_last;
    logic                last_stop;
    logic                last_byte;

`ifdef UART_WORD_TX_PARITY_EN
    logic                par_acc;
`else
    logic                unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign tick_last   = (tick_cnt == TICK_LAST);
    assign last_stop   = (bit_cnt == STOP_LAST);
    assign last_byte   = (byte_cnt == BYTE_LAST);

    assign s_if.s_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            tx_line   <= 1'b1;
            word_done <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                tx_line  <= 1'b1;
                if (s_if.s_valid) begin
                    shreg    <= s_if.s_data;
                    byte_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_line  <= 1'b0;
                    state    <= START;
                end
            end else if (!tick_last) begin
                tick_cnt <= tick_cnt + 1'b1;
            end else begin
                // Bit boundary: the next line level is registered here so it
                // appears on the very first cycle of the following bit.
                tick_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx_line <= shreg[0];
`ifdef UART_WORD_TX_PARITY_EN
                        par_acc <= shreg[0];
`endif
                    end
                    DATA: begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_WORD_TX_PARITY_EN
                            state   <= PARITY;
                            tx_line <= par_acc ^ (PARITY_ODD != 0);
`else
                            state   <= STOP;
                            tx_line <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_line <= shreg[1];
`ifdef UART_WORD_TX_PARITY_EN
                            par_acc <= par_acc ^ shreg[1];
`endif
                        end
                    end
`ifdef UART_WORD_TX_PARITY_EN
                    PARITY: begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx_line <= 1'b1;
                    end
`endif
                    STOP: begin
                        if (!last_stop) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (last_byte) begin
                            state     <= IDLE;
                            bit_cnt   <= '0;
                            byte_cnt  <= '0;
                            word_done <= 1'b1;
                        end else begin
                            // Next byte starts straight away, no idle gap.
                            state    <= START;
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt + 1'b1;
                            tx_line  <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx_line <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a frame-level model predicts every output cycle, plus
// directed scenarios with hand-computed line bytes and word_done timing.
module tb_uart_word_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int BT     = 10;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int P  = 1;
    localparam int ND = 4;
`else
    localparam int P  = 0;
    localparam int ND = 2;
`endif
    localparam int F0 = 10 + P;        // bits per byte frame, dut 0
    localparam int F1 = 11 + P;        // bits per byte frame, dut 1 (two stop bits)

    function automatic int wb_of(int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int sb_of(int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic int po_of(int k);
        return (k == 3) ? 1 : 0;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] drv_data  [ND];
    logic        drv_valid [ND];
    logic        tx_a [ND];
    logic        busy_a [ND];
    logic        rdy_a [ND];
    logic        wd_a [ND];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUTs, model and per-cycle compare ----------------
    for (genvar k = 0; k < ND; k++) begin : g_dut
        localparam int WB = wb_of(k);
        localparam int SB = sb_of(k);
        localparam int PO = po_of(k);

        uart_word_tx_if #(.WORD_BYTES(WB)) ifc ();
        logic       tx, busy, wd;
        logic [2:0] dbg_unused;
        logic [3:0] exp_q[$];          // {tx_line, busy, s_ready, word_done} per cycle

        assign ifc.s_data  = drv_data[k][8*WB-1:0];
        assign ifc.s_valid = drv_valid[k];

        uart_word_tx #(
            .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .WORD_BYTES(WB),
            .STOP_BITS(SB), .PARITY_ODD(PO)
        ) dut (
            .clk(clk), .rst_n(rst_n), .s_if(ifc.slave),
            .tx_line(tx), .busy(busy), .word_done(wd), .dbg_state(dbg_unused)
        );

        assign tx_a[k]   = tx;
        assign busy_a[k] = busy;
        assign rdy_a[k]  = ifc.s_ready;
        assign wd_a[k]   = wd;

        // The block is free exactly when no predicted frame cycles remain.
        always @(posedge clk) begin
            logic [7:0] byt;
            logic       bits[$];
            if (rst_n && drv_valid[k] && exp_q.size() == 0) begin
                bits.delete();
                for (int b = 0; b < WB; b++) begin
                    byt = drv_data[k][8*b +: 8];
                    bits.push_back(1'b0);
                    for (int i = 0; i < 8; i++) bits.push_back(byt[i]);
                    if (P == 1) bits.push_back((^byt) ^ (PO != 0));
                    for (int s = 0; s < SB; s++) bits.push_back(1'b1);
                end
                foreach (bits[j])
                    for (int t = 0; t < BT; t++) exp_q.push_back({bits[j], 3'b100});
                exp_q.push_back(4'b1011);
            end
        end

        always @(negedge rst_n) exp_q.delete();

        always @(negedge clk) begin
            logic [3:0] e;
            if (!rst_n || exp_q.size() == 0) e = 4'b1010;
            else e = exp_q.pop_front();
            check($sformatf("dut%0d_outputs", k), {60'd0, tx, busy, ifc.s_ready, wd}, {60'd0, e});
        end
    end

    // ---------------- driver tasks ----------------
    logic line_tr[$];
    int   wd_idx;
    logic busy_ok;

    task automatic send_word(input int k, input logic [63:0] d);
        @(negedge clk);
        drv_data[k]  = d;
        drv_valid[k] = 1'b1;
        @(negedge clk);
        drv_valid[k] = 1'b0;
    endtask

    // Records tx_line from the current negedge on; optionally pulses s_valid at index inj_at.
    task automatic capture(input int k, input int n, input int inj_at, input logic [63:0] inj_data);
        line_tr.delete();
        wd_idx  = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (i == inj_at) begin
                drv_data[k]  = inj_data;
                drv_valid[k] = 1'b1;
            end else if (i == inj_at + 1) begin
                drv_valid[k] = 1'b0;
            end
            line_tr.push_back(tx_a[k]);
            if (wd_a[k] && wd_idx < 0) wd_idx = i;
            if (wd_idx < 0 && !busy_a[k]) busy_ok = 1'b0;
        end
    endtask

    function automatic logic [7:0] rx_byte(input int b, input int f);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = line_tr[(b*f + 1 + i)*BT + BT/2];
        return v;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] exp_b [4];
        int t;
        int hi;
        rst_n = 1'b0;
        for (int k = 0; k < ND; k++) begin
            drv_valid[k] = 1'b0;
            drv_data[k]  = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_tx_line", {63'd0, tx_a[0]}, 64'd1);
        check("reset_busy", {63'd0, busy_a[0]}, 64'd0);
        check("reset_s_ready", {63'd0, rdy_a[0]}, 64'd1);
        check("reset_word_done", {63'd0, wd_a[0]}, 64'd0);
        rst_n = 1'b1;

        // Single word, with a word offered mid-frame that must be dropped
        send_word(0, 64'hA5C3_0F81);
        capture(0, 4*F0*BT + 20, 100, 64'hDEAD_BEEF);
        check("single_done_cycle", 64'(wd_idx), 64'(4*F0*BT));
        check("single_busy_held", {63'd0, busy_ok}, 64'd1);
        exp_b = '{8'h81, 8'h0F, 8'hC3, 8'hA5};
        for (int b = 0; b < 4; b++)
            check($sformatf("single_byte%0d", b), {56'd0, rx_byte(b, F0)}, {56'd0, exp_b[b]});
        check("single_start_bit", {63'd0, line_tr[BT/2]}, 64'd0);
        check("single_stop_bit", {63'd0, line_tr[(F0-1)*BT + BT/2]}, 64'd1);
        repeat (20) @(negedge clk);
        check("ignored_word_idle", {63'd0, busy_a[0]}, 64'd0);

        // Back-to-back words with s_valid held high
        @(negedge clk);
        drv_data[0]  = 64'h0000_00FF;
        drv_valid[0] = 1'b1;
        @(negedge clk);
        drv_data[0]  = 64'hFFFF_FF00;
        check("b2b_first_accept", {63'd0, busy_a[0]}, 64'd1);
        t = 0;
        while (!wd_a[0] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_done", 64'(t), 64'(4*F0*BT));
        @(negedge clk);
        check("b2b_second_start_tx", {63'd0, tx_a[0]}, 64'd0);
        check("b2b_second_busy", {63'd0, busy_a[0]}, 64'd1);
        drv_valid[0] = 1'b0;
        t = 0;
        while (!wd_a[0] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_second_done", 64'(t), 64'(4*F0*BT));
        repeat (5) @(negedge clk);

        // Two stop bits, two-byte word
        send_word(1, 64'h1234);
        capture(1, 2*F1*BT + 10, -1, 64'd0);
        check("stop2_done_cycle", 64'(wd_idx), 64'(2*F1*BT));
        check("stop2_byte0", {56'd0, rx_byte(0, F1)}, 64'h34);
        check("stop2_byte1", {56'd0, rx_byte(1, F1)}, 64'h12);
        for (int b = 0; b < 2; b++) begin
            hi = 0;
            for (int i = (b*F1 + 9 + P)*BT; i < (b+1)*F1*BT; i++) hi += int'(line_tr[i]);
            check($sformatf("stop2_high_run%0d", b), 64'(hi), 64'(2*BT));
        end
        check("stop2_next_start", {63'd0, line_tr[F1*BT]}, 64'd0);
        repeat (5) @(negedge clk);

        // Reset in bit 3 of byte 1, then a fresh word on the first edge
        send_word(0, 64'h1234_5678);
        repeat ((F0 + 1 + 3)*BT + BT/2) @(negedge clk);
        check("midreset_pre_tx", {63'd0, tx_a[0]}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_tx_line", {63'd0, tx_a[0]}, 64'd1);
        check("midreset_busy", {63'd0, busy_a[0]}, 64'd0);
        check("midreset_s_ready", {63'd0, rdy_a[0]}, 64'd1);
        repeat (3) @(negedge clk);
        drv_data[0]  = 64'h0F0F_3C3C;
        drv_valid[0] = 1'b1;
        rst_n        = 1'b1;
        @(negedge clk);
        drv_valid[0] = 1'b0;
        check("postreset_first_edge", {63'd0, busy_a[0]}, 64'd1);
        capture(0, 4*F0*BT + 10, -1, 64'd0);
        check("postreset_done_cycle", 64'(wd_idx), 64'(4*F0*BT));
        exp_b = '{8'h3C, 8'h3C, 8'h0F, 8'h0F};
        for (int b = 0; b < 4; b++)
            check($sformatf("postreset_byte%0d", b), {56'd0, rx_byte(b, F0)}, {56'd0, exp_b[b]});

`ifdef UART_WORD_TX_PARITY_EN
        // Single-byte words with parity: 8'h07 has three ones
        send_word(2, 64'h07);
        capture(2, 11*BT + 10, -1, 64'd0);
        check("parity_even_bit", {63'd0, line_tr[9*BT + BT/2]}, 64'd1);
        check("parity_even_frame", 64'(wd_idx), 64'(11*BT));
        send_word(3, 64'h07);
        capture(3, 11*BT + 10, -1, 64'd0);
        check("parity_odd_bit", {63'd0, line_tr[9*BT + BT/2]}, 64'd0);
        check("parity_odd_frame", 64'(wd_idx), 64'(11*BT));
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected scenario completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
